clk_div_prog: RTL

Runtime-programmable clock divider: the next generation of the fixed-N divider used by the UART baud and sample-clock paths. It divides `clk` by a divisor loaded at run time and produces a 50 %-duty `clk_out` for both even and odd divisors. It also provides a one-cycle `tick` strobe at each period start and a gated enable. Divisor changes and enable changes take effect only at period boundaries, so `clk_out` never shows a runt pulse.

---
 rtl/clk_div_prog.sv | 127 ++++++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with 50% duty for even and odd divisors.
// Divisor and enable changes are applied only at period boundaries.
module clk_div_prog #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic [WIDTH-1:0] div_cur,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] d_act_q, d_act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_pos_q, clk_pos_d;
  logic             clk_neg_q;
  logic             tick_q, tick_d;
  logic             div_ack_q, div_ack_d;

  logic [WIDTH-1:0] d_eff, h_cur, d_new, d_new_eff, cnt_inc;
  logic             boundary;

  // Divisor 0 aliases 1; d_new is the divisor governing a period started now.
  always_comb begin
    d_eff     = (d_act_q == '0) ? ONE : d_act_q;
    h_cur     = d_eff >> 1;
    d_new     = pend_v_q ? pend_q : d_act_q;
    d_new_eff = (d_new == '0) ? ONE : d_new;
    cnt_inc   = cnt_q + ONE;
    boundary  = (state_q == IDLE) || (cnt_q == d_eff - ONE);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      d_act_q   <= DIV_RST;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      clk_pos_q <= 1'b0;
      tick_q    <= 1'b0;
      div_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      d_act_q   <= d_act_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      clk_pos_q <= clk_pos_d;
      tick_q    <= tick_d;
      div_ack_q <= div_ack_d;
    end
  end

  // Half-cycle delayed copy used to stretch odd-divisor high phases
  always_ff @(negedge clk or posedge rst) begin
    if (rst) clk_neg_q <= 1'b0;
    else     clk_neg_q <= clk_pos_q;
  end

  // Next-state: phase counter, divisor application and pending capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    d_act_d  = d_act_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (boundary) begin
      cnt_d   = '0;
      state_d = en ? RUN : IDLE;
      if (pend_v_q) begin
        d_act_d  = pend_q;
        pend_v_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_inc;
    end
    // A load on a boundary edge is held for the following boundary
    if (div_load) begin
      pend_d   = div_in;
      pend_v_d = 1'b1;
    end
  end

  // Registered output next values
  always_comb begin
    tick_d    = 1'b0;
    div_ack_d = 1'b0;
    clk_pos_d = 1'b0;
    if (boundary) begin
      div_ack_d = pend_v_q;
      tick_d    = en;
      clk_pos_d = en && (d_new_eff > ONE);
    end else begin
      clk_pos_d = cnt_inc < h_cur;
    end
  end

  // Divided clock select: bypass for D==1, half-cycle stretch for odd D
  always_comb begin
    clk_out = 1'b0;
    if (state_q == RUN) begin
      if (d_eff == ONE)  clk_out = clk;
      else if (d_eff[0]) clk_out = clk_pos_q | clk_neg_q;
      else               clk_out = clk_pos_q;
    end
  end

  assign div_ack = div_ack_q;
  assign div_cur = d_act_q;
  assign tick    = tick_q;

endmodule
